// File: rtl/sa_autosa_sync_evt_pkg.sv
// Shared types and constants for the synchronized toggle-event receiver.
package sa_autosa_sync_evt_pkg;

  typedef enum logic [0:0] {
    StInit = 1'b0,
    StRun  = 1'b1
  } evt_rx_state_e;

  localparam int unsigned STAT_W = 16;

  // Largest value a saturating counter of the given width may hold.
  function automatic int unsigned max_cnt(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sa_autosa_tgl_edge_det.sv
// Toggle-level edge detector. The first cycle after reset only captures the level, so a
// source toggle already high across a destination-only reset does not look like an event.
module sa_autosa_tgl_edge_det
  import sa_autosa_sync_evt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_tgl_i,
  output logic edge_o
);

  evt_rx_state_e state_q, state_d;
  logic          tgl_q;

  always_comb begin
    state_d = state_q;
    edge_o  = 1'b0;
    unique case (state_q)
      StInit: state_d = StRun;
      StRun:  edge_o  = sync_tgl_i ^ tgl_q;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      tgl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgl_q   <= sync_tgl_i;
    end
  end

endmodule

// File: rtl/sa_autosa_sync_evt_rx.sv
// Destination-side event receiver: counts toggle edges into a saturating pending count and
// hands them out over valid/ready. Define SA_AUTOSA_SYNC_EVT_RX_STAT_EN for the evt_total port.
module sa_autosa_sync_evt_rx
  import sa_autosa_sync_evt_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             o_clk,
  input  logic             o_rstn,
  input  logic             sync_tgl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_pend,
  output logic             ovf,
  input  logic             ovf_clr
`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
  ,
  output logic [STAT_W-1:0] evt_total
`endif
);

  localparam logic [CNT_W-1:0] PendMax = CNT_W'(max_cnt(CNT_W));

  logic             tgl_edge;
  logic             pop;
  logic             ovf_set;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  sa_autosa_tgl_edge_det u_edge_det (
    .clk_i      (o_clk),
    .rst_ni     (o_rstn),
    .sync_tgl_i (sync_tgl),
    .edge_o     (tgl_edge)
  );

  // Valid comes straight from the registered count, so pop can never underflow.
  assign evt_valid = (pend_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign evt_pend  = pend_q;
  assign ovf       = ovf_q;

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (tgl_edge && !pop) begin
      if (pend_q == PendMax) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!tgl_edge && pop) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Set beats clear so an overflow coinciding with ovf_clr is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge o_clk or negedge o_rstn) begin
    if (!o_rstn) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
  logic [STAT_W-1:0] total_q;

  always_ff @(posedge o_clk or negedge o_rstn) begin
    if (!o_rstn) begin
      total_q <= '0;
    end else if (tgl_edge) begin
      total_q <= total_q + 1'b1;
    end
  end

  assign evt_total = total_q;
`endif

endmodule

// File: tb/tb_sa_autosa_sync_evt_rx.sv
// Directed self-checking bench for sa_autosa_sync_evt_rx.
module tb_sa_autosa_sync_evt_rx;

  localparam int unsigned CntW = 4;

  logic            o_clk;
  logic            o_rstn;
  logic            sync_tgl;
  logic            evt_valid;
  logic            evt_ready;
  logic [CntW-1:0] evt_pend;
  logic            ovf;
  logic            ovf_clr;
`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
  logic [15:0]     evt_total;
  logic [15:0]     total_base;
`endif

  int checks_cnt;
  int fail_cnt;
  int accepts;

  sa_autosa_sync_evt_rx #(
    .CNT_W (CntW)
  ) dut (
    .o_clk     (o_clk),
    .o_rstn    (o_rstn),
    .sync_tgl  (sync_tgl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pend  (evt_pend),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
    ,
    .evt_total (evt_total)
`endif
  );

  initial o_clk = 1'b0;
  always #5 o_clk = ~o_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge o_clk);
  endtask

  task automatic toggle_step();
    sync_tgl = ~sync_tgl;
    step();
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    o_rstn     = 1'b0;
    sync_tgl   = 1'b1;
    evt_ready  = 1'b0;
    ovf_clr    = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_pend", 32'(evt_pend), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
    check("rst_total", 32'(evt_total), 32'd0);
`endif

    // Level already high at release must not be taken as an event.
    o_rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("init_valid", 32'(evt_valid), 32'd0);
      check("init_pend", 32'(evt_pend), 32'd0);
    end

    toggle_step();
    check("single_pend", 32'(evt_pend), 32'd1);
    check("single_valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("single_pop_pend", 32'(evt_pend), 32'd0);
    check("single_pop_valid", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 5; i++) toggle_step();
    check("b2b_pend", 32'(evt_pend), 32'd5);
    evt_ready = 1'b1;
    accepts   = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_valid) accepts++;
      step();
    end
    evt_ready = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd5);
    check("b2b_valid", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 3; i++) toggle_step();
    check("simul_pre", 32'(evt_pend), 32'd3);
    evt_ready = 1'b1;
    toggle_step();
    check("simul_pend", 32'(evt_pend), 32'd3);
    repeat (3) step();
    evt_ready = 1'b0;
    check("drain_pend", 32'(evt_pend), 32'd0);

`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
    total_base = evt_total;
`endif
    for (int i = 0; i < 15; i++) toggle_step();
    check("sat15_pend", 32'(evt_pend), 32'd15);
    check("sat15_ovf", 32'(ovf), 32'd0);
    toggle_step();
    check("sat16_pend", 32'(evt_pend), 32'd15);
    check("sat16_ovf", 32'(ovf), 32'd1);
    toggle_step();
    check("sat17_pend", 32'(evt_pend), 32'd15);
`ifdef SA_AUTOSA_SYNC_EVT_RX_STAT_EN
    check("sat_total", 32'(evt_total - total_base), 32'd17);
`endif

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_pend", 32'(evt_pend), 32'd15);

    ovf_clr = 1'b1;
    toggle_step();
    ovf_clr = 1'b0;
    check("clr_vs_set_ovf", 32'(ovf), 32'd1);

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr2_ovf", 32'(ovf), 32'd0);
    // Edge plus pop at max is balanced, not an overflow.
    evt_ready = 1'b1;
    toggle_step();
    evt_ready = 1'b0;
    check("max_simul_pend", 32'(evt_pend), 32'd15);
    check("max_simul_ovf", 32'(ovf), 32'd0);

    evt_ready = 1'b1;
    repeat (8) step();
    evt_ready = 1'b0;
    check("pre_rst_pend", 32'(evt_pend), 32'd7);
    toggle_step();
    toggle_step();
    toggle_step();
    check("pre_rst_ovf_src", 32'(evt_pend), 32'd10);

    #2;
    o_rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_pend", 32'(evt_pend), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    sync_tgl = 1'b1;
    step();
    o_rstn = 1'b1;
    step();
    check("post_rst_init_pend", 32'(evt_pend), 32'd0);
    step();
    check("post_rst_run_pend", 32'(evt_pend), 32'd0);
    toggle_step();
    check("post_rst_evt_pend", 32'(evt_pend), 32'd1);
    check("post_rst_evt_valid", 32'(evt_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/sa_autosa_sync_evt_rx.md
Name: sa_autosa_sync_evt_rx

Overview:
- Destination-domain consumer of the 3-flop strict synchronizer output.
- Source domain encodes each event as a toggle of a single level; this block runs on the destination clock only.
- Detects each toggle edge, queues it in a saturating pending-event counter and presents events to a local consumer over a valid/ready handshake.
- Flags a sticky overflow when events arrive faster than they are drained.

Parameters:
- CNT_W, 4, width of pending-event counter; max pending = 2^CNT_W-1 (15 at default).

Ports:
- o_clk  in  1  destination clock (single clock of this block)
- o_rstn  in  1  reset, asynchronous assert, active-low
- sync_tgl  in  1  synchronized toggle level from synchronizer sync_o
- evt_valid  out  1  at least one event pending
- evt_ready  in  1  consumer accepts one event when evt_valid&&evt_ready
- evt_pend  out  CNT_W  current pending count
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset values: evt_valid=0, evt_pend=0, ovf=0, tgl_q=0, FSM=INIT.
- FSM state INIT: entered on reset.
  - First o_clk edge after o_rstn deasserts: tgl_q<=sync_tgl, no event generated, go to RUN.
  - This suppresses a false edge when the source toggle is already 1 across a destination-only reset.
- FSM state RUN: every cycle tgl_q<=sync_tgl and edge=sync_tgl^tgl_q (combinational). RUN is held until reset.
- Pending-count update per cycle, with pop=evt_valid&&evt_ready:
  - edge&&!pop: pend+1.
  - !edge&&pop: pend-1.
  - edge&&pop: pend unchanged (simultaneous inc/dec nets to zero).
  - Neither: unchanged.
- Saturation: edge&&!pop with pend==max leaves pend at max, drops the event and sets ovf. edge&&pop at max is not an overflow.
- evt_valid = (evt_pend!=0), driven from the registered count; no combinational path from evt_ready or sync_tgl to any output.
- Latency: sync_tgl toggles in cycle N, so pend increments at the end of N and evt_valid is high in N+1.
- Holding evt_ready high drains one event per cycle; back-to-back toggles on consecutive cycles are each counted.
- Underflow is impossible: pop requires pend!=0.
- ovf_clr: ovf<=0 next cycle. If an overflow occurs in the same cycle as ovf_clr, set wins and ovf stays 1.
- Reset asserted mid-operation: all state clears asynchronously, pending events are discarded and the FSM returns to INIT.
- Width rule: counter arithmetic is CNT_W bits with explicit saturation; it never wraps.

Optional Feature:
- Macro: SA_AUTOSA_SYNC_EVT_RX_STAT_EN.
- Defined:
  - Adds output port evt_total [15:0], reset 0.
  - Increments on every detected edge in RUN, including events dropped on overflow.
  - Wraps 0xFFFF->0x0000; not affected by ovf_clr.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package sa_autosa_sync_evt_pkg:
  - FSM state enum {INIT, RUN}.
  - Constant STAT_W=16.
  - Function returning max count for a given CNT_W.
- Sub-module sa_autosa_tgl_edge_det: INIT/RUN FSM plus tgl_q register; outputs a 1-cycle edge strobe.
- Top level holds the counter, handshake and ovf logic.

Test Plan:
- Init suppression: sync_tgl=1 held through reset release -> no evt_valid, evt_pend=0 for 10 cycles.
- Single event: evt_ready=0, toggle sync_tgl 0->1 at cycle N -> evt_pend=1 and evt_valid=1 at N+1. Then evt_ready=1 for one cycle -> evt_pend=0 and evt_valid=0 the next cycle.
- Back-to-back: 5 toggles on consecutive cycles with evt_ready=0 -> evt_pend=5. Then evt_ready=1 -> exactly 5 accepts, evt_valid drops after the 5th.
- Simultaneous: pend=3 with a toggle and evt_ready=1 in the same cycle -> pend stays 3.
- Saturation:
  - 17 toggles with evt_ready=0, CNT_W=4 -> pend=15, ovf=1 after the 16th toggle; with STAT_EN, evt_total=17.
  - ovf_clr pulse -> ovf=0.
  - Overflow in the same cycle as ovf_clr -> ovf=1.
- Mid-op reset: pend=7, assert o_rstn low asynchronously -> evt_valid=0, evt_pend=0, ovf=0 immediately. After release, the first cycle is INIT with no event.
